// File: rtl/sd_converter_pkg.sv
// Shared definitions for the stochastic-to-digital converter.
package sd_converter_pkg;

    // Converter states, encoded to match the rest of the stochastic toolchain.
    typedef enum logic [1:0] {
        SD_IDLE  = 2'd0,
        SD_ACCUM = 2'd1,
        SD_HOLD  = 2'd2
    } sd_state_e;

    // Window length in qualified bits: one full maximal-length LFSR period.
    function automatic int sd_window_len(input int precision);
        return (1 << precision) - 1;
    endfunction

endpackage

// File: rtl/sc_counter.sv
// Parameterised up-counter with synchronous clear, enable and terminal-count flag.
module sc_counter #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] TC_VALUE = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_q;

    // Next count: clear wins over enable.
    always_comb begin
        // NOTE: assign the default first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == TC_VALUE);

endmodule

// File: rtl/sd_converter.sv
// Stochastic-to-digital converter: counts ones over one LFSR period of qualified bits.
module sd_converter
    import sd_converter_pkg::*;
#(
    parameter int PRECISION = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic                 in,
    input  logic                 out_ready,
    output logic [PRECISION-1:0] out,
    output logic                 out_valid,
    output logic                 busy
);

    // Index value just before the final bit of the window is accepted.
    localparam logic [PRECISION-1:0] PRE_LAST = PRECISION'(sd_window_len(PRECISION) - 1);

    sd_state_e            state_d, state_q;
    logic [PRECISION-1:0] out_d, out_q;
    logic                 out_valid_d, out_valid_q;
    logic                 busy_d, busy_q;

    logic                 cnt_clear;
    logic                 ones_en;
    logic                 idx_en;
    logic [PRECISION-1:0] ones_cnt;
    logic                 last_bit;
    logic                 ones_tc_unused;
    logic [PRECISION-1:0] idx_cnt_unused;

    sc_counter #(
        .WIDTH    (PRECISION),
        .TC_VALUE ('1)
    ) u_ones (
        .clk     (clk),
        .rst     (rst),
        .clear_i (cnt_clear),
        .en_i    (ones_en),
        .cnt_o   (ones_cnt),
        .tc_o    (ones_tc_unused)
    );

    sc_counter #(
        .WIDTH    (PRECISION),
        .TC_VALUE (PRE_LAST)
    ) u_index (
        .clk     (clk),
        .rst     (rst),
        .clear_i (cnt_clear),
        .en_i    (idx_en),
        .cnt_o   (idx_cnt_unused),
        .tc_o    (last_bit)
    );

    // Next-state, counter controls and registered-output next values.
    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        cnt_clear = 1'b0;
        ones_en   = 1'b0;
        idx_en    = 1'b0;
        case (state_q)
            SD_IDLE: begin
                if (start) begin
                    state_d   = SD_ACCUM;
                    cnt_clear = 1'b1;
                end
            end
            SD_ACCUM: begin
                if (in_valid) begin
                    idx_en  = 1'b1;
                    ones_en = in;
                    if (last_bit) begin
                        // The final bit is folded in here since the counter only updates at this edge.
                        out_d   = ones_cnt + {{(PRECISION-1){1'b0}}, in};
                        state_d = SD_HOLD;
                    end
                end
            end
            SD_HOLD: begin
                if (out_ready) begin
                    if (start) begin
                        state_d   = SD_ACCUM;
                        cnt_clear = 1'b1;
                    end else begin
                        state_d = SD_IDLE;
                    end
                end
            end
            default: state_d = SD_IDLE;
        endcase
        busy_d      = (state_d == SD_ACCUM);
        out_valid_d = (state_d == SD_HOLD);
    end

    // State and output registers; reset discards any partial window.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= SD_IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sd_converter.sv
// Self-checking bench for sd_converter with a queue-based reference model.
module tb_sd_converter;

    localparam int P   = 4;
    localparam int WIN = (1 << P) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         in_valid = 1'b0;
    logic         in = 1'b0;
    logic         out_ready = 1'b0;
    logic [P-1:0] out;
    logic         out_valid;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    sd_converter #(.PRECISION(P)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in        (in),
        .out_ready (out_ready),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collect accepted bits of the current window, count ones once full.
    bit     model_on = 1'b0;
    bit     m_accum  = 1'b0;
    bit     m_hold   = 1'b0;
    int     m_out    = 0;
    bit     acc_q[$];

    function automatic int ones_in(input bit q[$]);
        int s = 0;
        foreach (q[i]) s += int'(q[i]);
        return s;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_accum  <= 1'b0;
            m_hold   <= 1'b0;
            m_out    <= 0;
            model_on <= 1'b1;
            acc_q.delete();
        end else if (m_accum) begin
            if (in_valid) begin
                acc_q.push_back(in);
                if (acc_q.size() == WIN) begin
                    m_out   <= ones_in(acc_q);
                    m_accum <= 1'b0;
                    m_hold  <= 1'b1;
                end
            end
        end else if (m_hold) begin
            if (out_ready) begin
                m_hold  <= 1'b0;
                m_accum <= start;
                acc_q.delete();
            end
        end else if (start) begin
            m_accum <= 1'b1;
            acc_q.delete();
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (model_on) begin
            check("cyc_out", 32'(out), 32'(m_out));
            check("cyc_out_valid", 32'(out_valid), 32'(m_hold));
            check("cyc_busy", 32'(busy), 32'(m_accum));
        end
    end

    // Apply inputs for one cycle; returns shortly after the consuming edge.
    task automatic drive(input bit r, input bit s, input bit v, input bit b, input bit rdy);
        rst       = r;
        start     = s;
        in_valid  = v;
        in        = b;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [3:0] lfsr;
    int         ones_seen;
    logic [P-1:0] held_out;

    initial begin
        // 1. Reset with every other input active.
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
            check("rst_out", 32'(out), 32'd0);
            check("rst_valid", 32'(out_valid), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
            check("idle_busy", 32'(busy), 32'd0);
        end

        // 2. Full ones window.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("full_busy_start", 32'(busy), 32'd1);
        for (int i = 0; i < WIN; i++) begin
            if (i == WIN - 1) check("full_busy_last", 32'(busy), 32'd1);
            drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        check("full_out", 32'(out), 32'd15);
        check("full_valid", 32'(out_valid), 32'd1);
        check("full_busy_done", 32'(busy), 32'd0);
        check("model_full", 32'(m_out), 32'd15);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("full_ack_valid", 32'(out_valid), 32'd0);
        check("full_ack_out", 32'(out), 32'd15);

        // 3a. One on every third bit.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < WIN; i++) drive(1'b1, 1'b0, 1'b1, (i % 3) == 2, 1'b0);
        check("third_out", 32'(out), 32'd5);
        check("model_third", 32'(m_out), 32'd5);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // 3b. SNG for value 8 over one LFSR period.
        lfsr = 4'd1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < WIN; i++) begin
            drive(1'b1, 1'b0, 1'b1, (lfsr - 4'd1) < 4'd8, 1'b0);
            lfsr = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
        end
        check("sng8_out", 32'(out), 32'd8);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // 4. in_valid alternating with ones on the gaps too.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2 * WIN - 1; i++) begin
            if (i == 2 * WIN - 2) check("gap_not_done", 32'(out_valid), 32'd0);
            drive(1'b1, 1'b0, (i % 2) == 0, 1'b1, 1'b0);
        end
        check("gap_valid", 32'(out_valid), 32'd1);
        check("gap_out", 32'(out), 32'd15);

        // 5. Backpressure with ignored start pulses, then back-to-back start.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        ones_seen = 0;
        for (int i = 0; i < WIN; i++) begin
            in = 1'($urandom_range(0, 1));
            ones_seen += int'(in);
            drive(1'b1, 1'b0, 1'b1, in, 1'b0);
        end
        check("bp_out", 32'(out), 32'(ones_seen));
        held_out = out;
        for (int i = 0; i < 10; i++) drive(1'b1, (i % 2) == 0, 1'b1, 1'b1, 1'b0);
        check("bp_hold_out", 32'(out), 32'(held_out));
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_hold_busy", 32'(busy), 32'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < WIN; i++) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("b2b_zero_out", 32'(out), 32'd0);
        check("b2b_zero_valid", 32'(out_valid), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // 6. Mid-window reset discards the partial count.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out", 32'(out), 32'd0);
        idle_cycle();
        check("mid_rst_idle", 32'(busy), 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < WIN; i++) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("fresh_out", 32'(out), 32'd0);
        check("fresh_valid", 32'(out_valid), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic, checked every cycle against the model.
        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(0, 299) != 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0);
        end

        idle_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
